// File: rtl/ula_mc.sv
// ============================================================================
// Module      : ula_mc
// Description : Multicycle ALU. Logic, arithmetic, compare, shift and branch
//               decision complete in one cycle; MUL runs an iterative
//               shift-add loop of WIDTH steps. Results, flags and the branch
//               take bit are registered and held until the next done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_mc #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       cmd,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             take
);

    localparam int SHAMT_BITS = $clog2(WIDTH);

    localparam logic [3:0] c_cmd_and  = 4'b0000;
    localparam logic [3:0] c_cmd_or   = 4'b0001;
    localparam logic [3:0] c_cmd_add  = 4'b0010;
    localparam logic [3:0] c_cmd_sub  = 4'b0110;
    localparam logic [3:0] c_cmd_slt  = 4'b0111;
    localparam logic [3:0] c_cmd_sltu = 4'b1000;
    localparam logic [3:0] c_cmd_xor  = 4'b1001;
    localparam logic [3:0] c_cmd_sll  = 4'b1010;
    localparam logic [3:0] c_cmd_srl  = 4'b1011;
    localparam logic [3:0] c_cmd_sra  = 4'b1100;
    localparam logic [3:0] c_cmd_mul  = 4'b1101;
    localparam logic [3:0] c_cmd_br   = 4'b1111;

    localparam logic [SHAMT_BITS-1:0] c_cnt_one  = SHAMT_BITS'(1);
    localparam logic [SHAMT_BITS-1:0] c_cnt_last = SHAMT_BITS'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q,  state_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic [WIDTH-1:0]      result_q, result_d;
    logic [3:0]            flags_q,  flags_d;
    logic                  take_q,   take_d;
    logic [SHAMT_BITS-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0]      acc_q,    acc_d;
    logic [WIDTH-1:0]      mcand_q,  mcand_d;
    logic [WIDTH-1:0]      mplier_q, mplier_d;

    logic [WIDTH-1:0]      w_sum;
    logic [WIDTH-1:0]      w_diff;
    logic [SHAMT_BITS-1:0] w_shamt;
    logic                  w_ovf_add;
    logic                  w_ovf_sub;
    logic                  w_ltu;
    logic                  w_lts;
    logic [WIDTH-1:0]      w_res;
    logic                  w_ovf;
    logic                  w_ltu_flag;
    logic                  w_take;
    logic [WIDTH-1:0]      w_step_acc;

    // Packs {ltu, overflow, msb, zero} from a final result.
    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic ovf,
                                            input logic ltu);
        return {ltu, ovf, r[WIDTH-1], (r == '0)};
    endfunction

    // Single-cycle datapath, evaluated on the live inputs so the accept edge
    // can register the final result directly.
    always_comb begin
        w_sum      = a + b;
        w_diff     = a - b;
        w_shamt    = b[SHAMT_BITS-1:0];
        w_ovf_add  = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1]  != a[WIDTH-1]);
        w_ovf_sub  = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
        w_ltu      = (a < b);
        w_lts      = ($signed(a) < $signed(b));
        w_res      = '0;
        w_ovf      = 1'b0;
        w_ltu_flag = 1'b0;
        case (cmd)
            c_cmd_and:  w_res = a & b;
            c_cmd_or:   w_res = a | b;
            c_cmd_xor:  w_res = a ^ b;
            c_cmd_add: begin
                w_res = w_sum;
                w_ovf = w_ovf_add;
            end
            c_cmd_sub, c_cmd_br: begin
                w_res      = w_diff;
                w_ovf      = w_ovf_sub;
                w_ltu_flag = w_ltu;
            end
            c_cmd_slt:  w_res = {{(WIDTH-1){1'b0}}, w_lts};
            c_cmd_sltu: begin
                w_res      = {{(WIDTH-1){1'b0}}, w_ltu};
                w_ltu_flag = w_ltu;
            end
            c_cmd_sll:  w_res = a << w_shamt;
            c_cmd_srl:  w_res = a >> w_shamt;
            c_cmd_sra:  w_res = WIDTH'($signed(a) >>> w_shamt);
            default:    w_res = '0;
        endcase
    end

    // Branch decision from the a-b comparison; only BR may assert take.
    always_comb begin
        w_take = 1'b0;
        if (cmd == c_cmd_br) begin
            case (funct3)
                3'b000:  w_take = (w_diff == '0);
                3'b001:  w_take = (w_diff != '0);
                3'b100:  w_take = w_diff[WIDTH-1] ^ w_ovf_sub;
                3'b101:  w_take = ~(w_diff[WIDTH-1] ^ w_ovf_sub);
                3'b110:  w_take = w_ltu;
                3'b111:  w_take = ~w_ltu;
                default: w_take = 1'b0;
            endcase
        end
    end

    // One shift-add multiply step.
    always_comb begin
        w_step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Next-state logic: accept in IDLE or DONE (back-to-back), iterate in RUN.
    always_comb begin
        state_d  = state_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;
        flags_d  = flags_q;
        take_d   = take_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    if (cmd == c_cmd_mul) begin
                        state_d  = S_RUN;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = a;
                        mplier_d = b;
                    end else begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = w_res;
                        flags_d  = mk_flags(w_res, w_ovf, w_ltu_flag);
                        take_d   = w_take;
                    end
                end
            end
            S_RUN: begin
                busy_d   = 1'b1;
                acc_d    = w_step_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + c_cnt_one;
                if (cnt_q == c_cnt_last) begin
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = w_step_acc;
                    flags_d  = mk_flags(w_step_acc, 1'b0, 1'b0);
                    take_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any multiply in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            take_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            take_q   <= take_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;
    assign take   = take_q;

endmodule

`default_nettype wire

// File: doc/ula_mc.md
Name: ula_mc

Overview:
- Parametrised multicycle successor of the datapath ALU.
- Generalised in operand width and in operation set: logic, arithmetic, compare, shift, branch decision, and an iterative shift-add multiply.
- Operands and command are latched on a start/done handshake.
- Results, flags and a branch-take bit are registered and held for the control FSM and the PC mux.

Parameters:
- WIDTH, 64, operand/result width in bits; legal range 8..64, power of two.
- SHAMT_BITS, $clog2(WIDTH), derived localparam; shift amount is b[SHAMT_BITS-1:0].

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- cmd  in  4  operation select, latched at accept
- funct3  in  3  branch condition, latched at accept, used only by cmd BR
- a  in  WIDTH  operand A (rs1), latched at accept
- b  in  WIDTH  operand B (rs2/imm), latched at accept
- busy  out  1  high from the accept edge until the edge that raises done
- done  out  1  one-cycle pulse: result, flags and take are valid
- result  out  WIDTH  registered result, held until the next done
- flags  out  4  [0] zero, [1] msb, [2] signed overflow, [3] unsigned less (borrow)
- take  out  1  registered branch decision, held until the next done

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0, flags=0, take=0; any multiply in flight is aborted and its accumulators are cleared.
- States:
  - IDLE: busy=0. If start=1, latch a/b/cmd/funct3. Single-cycle cmd -> DONE. MUL -> RUN, with cnt=0, acc=0, mcand=a, mplier=b.
  - RUN: busy=1. Each cycle: if mplier[0], acc+=mcand; then mcand<<=1, mplier>>=1, cnt++. After the WIDTH-th step -> DONE.
  - DONE: busy=0, done=1 for exactly one cycle. Returns to IDLE; a start seen in this cycle is accepted (back-to-back issue).
- Latency:
  - Single-cycle ops: done one cycle after the accept edge.
  - MUL: done WIDTH+1 cycles after the accept edge.
- start while busy=1 is ignored; there is no queueing.
- cmd encoding (two's complement, WIDTH-bit wrap):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 0/1), 1000 SLTU (result 0/1), 1001 XOR.
  - 1010 SLL, 1011 SRL, 1100 SRA.
  - 1101 MUL: low WIDTH bits of a*b; sign-agnostic.
  - 1111 BR: result = a-b.
  - Reserved 0011, 0100, 0101, 1110: result=0, flags=0001 (zero), take=0; completes as a single-cycle op.
- Flags are computed from the final result:
  - zero = (result==0).
  - msb = result[WIDTH-1].
  - overflow: set only for ADD/SUB/BR, when operand signs would produce a sign-inconsistent result; 0 for all other ops.
  - ltu = unsigned a<b, for SUB/SLTU/BR; 0 for all other ops.
- take is 0 unless cmd=BR. For BR, decided by funct3:
  - 000 BEQ zero
  - 001 BNE !zero
  - 100 BLT (msb^overflow)
  - 101 BGE !(msb^overflow)
  - 110 BLTU ltu
  - 111 BGEU !ltu
  - 010/011: take=0.
- Shifts use only b[SHAMT_BITS-1:0]; upper bits of b are ignored.
- Inputs may change while busy; the latched copies are used.

Test Plan:
- Reset during RUN: reset high mid-MUL -> busy=0, done=0, result=0, flags=0 immediately (asynchronous). After release, a new start ADD 1+1 -> result=2 on the next done.
- WIDTH=64, ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> done one cycle after accept; result=0x8000_0000_0000_0000; flags: overflow=1, msb=1, zero=0.
- WIDTH=64, SUB a=5, b=5 -> result=0, zero=1, ltu=0. SUB a=1, b=2 -> result=all ones, msb=1, ltu=1, overflow=0.
- BR sweep, a=-1 (all ones), b=1:
  - funct3=100 BLT -> take=1
  - 110 BLTU -> take=0
  - 001 BNE -> take=1
  - 011 -> take=0
  - Non-BR cmd -> take=0.
- MUL a=12345, b=-3 (WIDTH=64) -> busy high 64 cycles, done at accept+65, result=-37035. A start pulsed during busy is ignored (no extra done).
- Back-to-back: start held high across DONE, SLL a=1 b=0x43 then SRA a=0x8000_0000_0000_0000 b=63 -> first result=8 (shamt=3); second done on the next cycle with result=all ones.
